pipe_ctrl: RTL and testbench

//  Pipeline scheduler for the 5-stage core. It sequences the IF/ID, ID/EX and EX/MEM

---
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline scheduler for the 5-stage core: load-use stalls, redirect flushes, D-mem freezes, ECALL halt/resume.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_r1,
  input  logic [4:0] id_r2,
  input  logic       id_use_r1,
  input  logic       id_use_r2,
  input  logic       id_sys,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_re,
  input  logic       ex_reg_wr,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ack,
  input  logic       resume,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       if_id_flush,
  output logic       id_ex_we,
  output logic       id_ex_flush,
  output logic       ex_mem_we,
  output logic       halted,
  output logic [1:0] state
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_freeze
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2,
    HALT    = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   hz, hz_eff, freeze, freeze_hold;

  assign hz = ex_mem_re & ex_reg_wr & (ex_rd != 5'd0) &
              ((id_use_r1 & (id_r1 == ex_rd)) | (id_use_r2 & (id_r2 == ex_rd)));
  // EX already holds the bubble while in LDSTALL, so the hazard is not re-raised.
  assign hz_eff = hz & (state_q != LDSTALL);
  // mem_req/mem_ack: an access completes on the cycle both are high; req without ack freezes the pipe.
  assign freeze      = mem_req & ~mem_ack;
  assign freeze_hold = freeze | ((state_q == MEMWAIT) & ~mem_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HALT: begin
        if (!freeze && resume) state_d = RUN;
      end
      default: begin
        if (freeze_hold)      state_d = MEMWAIT;
        else if (ex_redirect) state_d = RUN;
        else if (hz_eff)      state_d = LDSTALL;
        else if (id_sys)      state_d = HALT;
        else                  state_d = RUN;
      end
    endcase
  end

  always_comb begin
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_we    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_we   = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      halted = (state_q == HALT);
      case (state_q)
        HALT: begin
          if (!freeze) begin
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
            if (resume) begin
              if_id_we    = 1'b1;
              if_id_flush = 1'b1;
            end
          end
        end
        default: begin
          if (freeze_hold) begin
            pc_we = 1'b0;
          end else if (ex_redirect) begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
          end else if (hz_eff || id_sys) begin
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
          end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
          end
        end
      endcase
    end
  end

  assign state = state_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic stall_evt, flush_evt, freeze_evt;

  // All load enables low only happens in a freeze cycle (reset also zeroes them, hence the rst term).
  assign freeze_evt = rst & ~pc_we & ~if_id_we & ~id_ex_we & ~ex_mem_we;
  assign flush_evt  = pc_we & id_ex_flush;
  assign stall_evt  = id_ex_flush & ~if_id_we & (state_q != HALT) & (state_d == LDSTALL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_stall  <= '0;
      cnt_flush  <= '0;
      cnt_freeze <= '0;
    end else begin
      if (stall_evt)  cnt_stall  <= cnt_stall + 1'b1;
      if (flush_evt)  cnt_flush  <= cnt_flush + 1'b1;
      if (freeze_evt) cnt_freeze <= cnt_freeze + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a rule-level scheduler model.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_r1, id_r2, ex_rd;
  logic       id_use_r1, id_use_r2, id_sys;
  logic       ex_mem_re, ex_reg_wr, ex_redirect;
  logic       mem_req, mem_ack, resume;
  logic       pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, halted;
  logic [1:0] state;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] cnt_stall, cnt_flush, cnt_freeze;
`endif

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_r1(id_r1), .id_r2(id_r2), .id_use_r1(id_use_r1), .id_use_r2(id_use_r2),
    .id_sys(id_sys), .ex_rd(ex_rd), .ex_mem_re(ex_mem_re), .ex_reg_wr(ex_reg_wr),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack), .resume(resume),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
    .halted(halted), .state(state)
`ifdef PIPE_CTRL_PERF_CNT_EN
    , .cnt_stall(cnt_stall), .cnt_flush(cnt_flush), .cnt_freeze(cnt_freeze)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  wire [8:0] dut_v = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we,
                      halted, state};

  // ---------------- behavioural model ----------------
  localparam int A_FRZ = 0, A_RDR = 1, A_STL = 2, A_SYS = 3, A_DRN = 4, A_RES = 5, A_NRM = 6;

  function automatic int decide(input int st, output int nxt);
    bit frz;
    bit hz;
    frz = mem_req && !mem_ack;
    hz  = ex_mem_re && ex_reg_wr && (ex_rd != 0) &&
          ((id_use_r1 && id_r1 == ex_rd) || (id_use_r2 && id_r2 == ex_rd));
    if (st == 3) begin
      if (frz)    begin nxt = 3; return A_FRZ; end
      if (resume) begin nxt = 0; return A_RES; end
      nxt = 3; return A_DRN;
    end
    if (frz || (st == 2 && !mem_ack)) begin nxt = 2; return A_FRZ; end
    if (ex_redirect)       begin nxt = 0; return A_RDR; end
    if (hz && st != 1)     begin nxt = 1; return A_STL; end
    if (id_sys)            begin nxt = 3; return A_SYS; end
    nxt = 0;
    return A_NRM;
  endfunction

  // enables ordered pc, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we
  function automatic logic [8:0] outs(input int act, input int st);
    logic [5:0] we;
    case (act)
      A_FRZ:               we = 6'b000000;
      A_RDR:               we = 6'b111111;
      A_STL, A_SYS, A_DRN: we = 6'b000111;
      A_RES:               we = 6'b011111;
      default:             we = 6'b110101;
    endcase
    return {we, (st == 3), 2'(st)};
  endfunction

  int          mdl_st;
  int          upd_a, upd_nx;
  logic [31:0] m_stall, m_flush, m_frz;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_st  <= 0;
      m_stall <= 0;
      m_flush <= 0;
      m_frz   <= 0;
    end else begin
      upd_a = decide(mdl_st, upd_nx);
      mdl_st <= upd_nx;
      if (upd_a == A_STL) m_stall <= m_stall + 1;
      if (upd_a == A_RDR) m_flush <= m_flush + 1;
      if (upd_a == A_FRZ) m_frz   <= m_frz + 1;
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  int         cmp_a, cmp_nx;
  logic [8:0] cmp_e;

  always @(negedge clk) begin
    if (!rst) cmp_e = 9'b0;
    else begin
      cmp_a = decide(mdl_st, cmp_nx);
      cmp_e = outs(cmp_a, mdl_st);
    end
    n_checks++;
    if (dut_v !== cmp_e) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, dut_v, cmp_e);
    end
`ifdef PIPE_CTRL_PERF_CNT_EN
    n_checks++;
    if ({cnt_stall, cnt_flush, cnt_freeze} !== {m_stall, m_flush, m_frz}) begin
      n_fail++;
      $display("FAIL model_cnt t=%0t got=%0d/%0d/%0d exp=%0d/%0d/%0d", $time,
               cnt_stall, cnt_flush, cnt_freeze, m_stall, m_flush, m_frz);
    end
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
    end
  endtask

  task automatic idle();
    id_r1 = 0; id_r2 = 0; id_use_r1 = 0; id_use_r2 = 0; id_sys = 0;
    ex_rd = 0; ex_mem_re = 0; ex_reg_wr = 0; ex_redirect = 0;
    mem_req = 0; mem_ack = 0; resume = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic lw_hz(input logic [4:0] rd);
    ex_mem_re = 1; ex_reg_wr = 1; ex_rd = rd;
    id_r1 = 0; id_use_r1 = 1; id_r2 = 5; id_use_r2 = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk); #1;
    #1 chk("reset_outs", 32'(dut_v), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("normal_after_reset", 32'(dut_v), 32'(9'b110101_0_00));

    nxt(); lw_hz(5);
    #1 chk("lduse_stall", 32'(dut_v), 32'(9'b000111_0_00));
    nxt(); lw_hz(5);
    #1 chk("ldstall_one_bubble", 32'(dut_v), 32'(9'b110101_0_01));
    nxt();
    #1 chk("ldstall_back_run", 32'(dut_v), 32'(9'b110101_0_00));

    nxt(); lw_hz(0);
    #1 chk("rd0_no_stall", 32'(dut_v), 32'(9'b110101_0_00));

    nxt(); lw_hz(5); ex_redirect = 1;
    #1 chk("redirect_over_hz", 32'(dut_v), 32'(9'b111111_0_00));
    nxt();
    #1 chk("redirect_next_run", 32'(dut_v), 32'(9'b110101_0_00));

    for (int i = 0; i < 3; i++) begin
      nxt(); mem_req = 1;
      #1 chk("freeze", 32'(dut_v), (i == 0) ? 32'(9'b000000_0_00) : 32'(9'b000000_0_10));
    end
    nxt(); mem_req = 1; mem_ack = 1;
    #1 chk("memwait_ack", 32'(dut_v), 32'(9'b110101_0_10));
    nxt();
    #1 chk("memwait_ack_run", 32'(dut_v), 32'(9'b110101_0_00));

    nxt(); id_sys = 1;
    #1 chk("sys_enter", 32'(dut_v), 32'(9'b000111_0_00));
    for (int i = 0; i < 10; i++) begin
      nxt(); id_sys = 1;
      #1 chk("halt_hold", 32'(dut_v), 32'(9'b000111_1_11));
    end
    nxt(); id_sys = 1; resume = 1;
    #1 chk("resume", 32'(dut_v), 32'(9'b011111_1_11));
    nxt();
    #1 chk("resume_refetch", 32'(dut_v), 32'(9'b110101_0_00));
    nxt(); resume = 1;
    #1 chk("resume_ignored", 32'(dut_v), 32'(9'b110101_0_00));

    nxt(); mem_req = 1;
    nxt(); mem_req = 1;
    #1 chk("memwait_before_rst", 32'(dut_v), 32'(9'b000000_0_10));
`ifdef PIPE_CTRL_PERF_CNT_EN
    chk("cnt_stall_one", cnt_stall, 32'd1);
    chk("cnt_flush_one", cnt_flush, 32'd1);
`endif
    rst = 1'b0;
    #1 chk("async_rst", 32'(dut_v), 32'h0);
`ifdef PIPE_CTRL_PERF_CNT_EN
    chk("cnt_rst", cnt_stall | cnt_flush | cnt_freeze, 32'd0);
`endif
    nxt(); mem_req = 1;
    nxt();
    rst = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      nxt();
      rst         = ($urandom_range(0, 199) != 0);
      id_r1       = 5'($urandom_range(0, 3));
      id_r2       = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_r1   = 1'($urandom_range(0, 1));
      id_use_r2   = 1'($urandom_range(0, 1));
      ex_mem_re   = 1'($urandom_range(0, 1));
      ex_reg_wr   = 1'($urandom_range(0, 1));
      id_sys      = ($urandom_range(0, 19) == 0);
      ex_redirect = ($urandom_range(0, 6) == 0);
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ack     = 1'($urandom_range(0, 1));
      resume      = ($urandom_range(0, 7) == 0);
    end

    nxt();
    rst = 1'b1;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
